k12a_lcd_ctl: RTL

K12A_LCD_CTL -- requirements
Module: k12a_lcd_ctl

---
 rtl/k12a_lcd_ctl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/k12a_lcd_ctl.sv
// k12a_lcd_ctl -- write-only HD44780 character LCD controller.
//
// The CPU pushes {rs, byte} entries into a small command FIFO. A sequencer
// pops one entry at a time. It drives lcd_rs/lcd_data, raises lcd_en for a
// fixed pulse, and then leaves an idle gap before it takes the next entry.
// In 4-bit mode each byte goes out as two transfers on lcd_data[7:4]: the
// high nibble first, then the low nibble.
//
// Ports
//   cpu_clock  in   single rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   wr_en      in   push request
//   wr_rs      in   register select of the pushed byte (0 cmd, 1 data)
//   wr_data    in   [7:0] byte to push
//   full       out  FIFO holds FIFO_DEPTH entries
//   idle       out  FIFO empty and sequencer in IDLE
//   overflow   out  sticky: a push was dropped because the FIFO was full
//   lcd_rs     out  LCD register select
//   lcd_rw     out  LCD read/write, always 0
//   lcd_en     out  LCD enable strobe (registered)
//   lcd_data   out  [7:0] LCD data bus
//
// State | meaning
// IDLE  | waiting for a FIFO entry; pops it and loads the bus on exit
// SETUP | rs/data valid, lcd_en low, SETUP_CYCLES cycles
// PULSE | lcd_en high, PULSE_CYCLES cycles
// HOLD  | lcd_en low, bus unchanged, 1 cycle
// GAP   | post-byte recovery, GAP_CYCLES cycles (skipped when 0)
module k12a_lcd_ctl #(
  parameter int NIBBLE_MODE  = 0,
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 8
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       idle,
  output logic       overflow,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int TMAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int TMAX    = (GAP_CYCLES > TMAX_SP) ? GAP_CYCLES : TMAX_SP;
  localparam int TW      = $clog2(TMAX + 1);

  // The timer holds the number of cycles left in the current state.
  // The state is left when the timer reaches 1.
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYCLES);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES);
  localparam logic [TW-1:0] ONE      = TW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [8:0]    head;

  logic          load_first, load_low;
  logic          low_phase;
  logic [7:0]    shift_q;

  // ---------------------------------------------------------------- FIFO
  // full is taken from the registered count. A pop in the same cycle
  // cannot rescue a push into a full FIFO.
  assign full = (count == CW'(FIFO_DEPTH));
  assign push = wr_en && !full;
  assign head = mem[rd_ptr];

  always_ff @(posedge cpu_clock) begin
    if (push) mem[wr_ptr] <= {wr_rs, wr_data};
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // ----------------------------------------------------------- sequencer
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    pop        = 1'b0;
    load_first = 1'b0;
    load_low   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          load_first = 1'b1;
          state_nxt  = ST_SETUP;
          timer_nxt  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (timer == ONE) begin
          state_nxt = ST_PULSE;
          timer_nxt = PULSE_LD;
        end else begin
          timer_nxt = timer - ONE;
        end
      end
      ST_PULSE: begin
        if (timer == ONE) begin
          state_nxt = ST_HOLD;
          timer_nxt = ONE;
        end else begin
          timer_nxt = timer - ONE;
        end
      end
      ST_HOLD: begin
        if ((NIBBLE_MODE != 0) && !low_phase) begin
          load_low  = 1'b1;
          state_nxt = ST_SETUP;
          timer_nxt = SETUP_LD;
        end else if (GAP_CYCLES > 0) begin
          state_nxt = ST_GAP;
          timer_nxt = GAP_LD;
        end else begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end
      end
      ST_GAP: begin
        if (timer == ONE) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer - ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // The bus registers change only when SETUP is entered.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      shift_q   <= 8'h00;
      low_phase <= 1'b0;
    end else begin
      lcd_en <= (state_nxt == ST_PULSE);
      if (load_first) begin
        lcd_rs    <= head[8];
        shift_q   <= head[7:0];
        low_phase <= 1'b0;
        lcd_data  <= (NIBBLE_MODE != 0) ? {head[7:4], 4'h0} : head[7:0];
      end else if (load_low) begin
        low_phase <= 1'b1;
        shift_q   <= {shift_q[3:0], 4'h0};
        lcd_data  <= {shift_q[3:0], 4'h0};
      end
    end
  end

  assign lcd_rw = 1'b0;
  assign idle   = (count == '0) && (state == ST_IDLE);

endmodule
